// File: rtl/exec_share_arbiter.sv
// exec_share_arbiter: two-requester arbiter in front of one 16-bit execution block, with lock/chain support.
// Optional EXS_CTX_CHECK_EN adds ctx_err and blocks context ops issued by a non-owner.
module exec_share_arbiter #(
  parameter int DW = 16,
  parameter int OPW = 6,
  parameter int LOCK_MAX = 4,
  parameter logic [OPW-1:0] IDLE_OP = 6'b011100
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           r0_req,
  input  logic           r0_lock,
  input  logic [OPW-1:0] r0_op,
  input  logic [DW-1:0]  r0_a,
  input  logic [DW-1:0]  r0_b,
  input  logic [DW-1:0]  r0_din,
  output logic           r0_gnt,
  input  logic           r1_req,
  input  logic           r1_lock,
  input  logic [OPW-1:0] r1_op,
  input  logic [DW-1:0]  r1_a,
  input  logic [DW-1:0]  r1_b,
  input  logic [DW-1:0]  r1_din,
  output logic           r1_gnt,
  output logic [OPW-1:0] ex_op,
  output logic [DW-1:0]  ex_a,
  output logic [DW-1:0]  ex_b,
  output logic [DW-1:0]  ex_din,
  input  logic [DW-1:0]  ex_ans,
  input  logic [1:0]     ex_flag,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_ans,
  output logic [1:0]     rsp_flag,
`ifdef EXS_CTX_CHECK_EN
  output logic           ctx_err,
`endif
  output logic           lock_brk
);
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_OWN0 = 2'b01;
  localparam logic [1:0] S_OWN1 = 2'b10;
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);
  logic [1:0] state_q, state_d;
  logic locked_q, locked_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rsp_valid_q, rsp_id_q, lock_brk_q;
  logic has_own, own, own_req, oth_req, hold, brk, any, gid, gnt, ctx_bad;
  logic [OPW-1:0] sel_op;
`ifdef EXS_CTX_CHECK_EN
  logic ctx_err_q;
  function automatic logic is_ctx(input logic [OPW-1:0] op);
    return op == 6'b010000 || op == 6'b010001 || op == 6'b010111 || op == 6'b011000 || op[5:2] == 4'b0111;
  endfunction
`endif
  always_comb begin
    has_own = state_q != S_IDLE;
    own = state_q == S_OWN1;
    own_req = has_own & (own ? r1_req : r0_req);
    oth_req = has_own & (own ? r0_req : r1_req);
    hold = locked_q & own_req & (cnt_q < LMAX);
    brk = locked_q & own_req & oth_req & (cnt_q == LMAX);
    any = r0_req | r1_req;
    // both requesting: the non-owner wins, and r0 wins from IDLE
    gid = hold ? own : (r0_req & r1_req) ? (has_own & ~own) : r1_req;
    gnt = any & ~reset;
    sel_op = gid ? r1_op : r0_op;
`ifdef EXS_CTX_CHECK_EN
    ctx_bad = is_ctx(sel_op) & (~has_own | (gid != own));
`else
    ctx_bad = 1'b0;
`endif
    state_d = any ? (gid ? S_OWN1 : S_OWN0) : state_q;
    locked_d = any & (gid ? r1_lock : r0_lock);
    cnt_d = (hold & oth_req) ? cnt_q + 1'b1 : '0;
  end
  assign r0_gnt = gnt & ~gid;
  assign r1_gnt = gnt & gid;
  assign ex_op = (gnt & ~ctx_bad) ? sel_op : IDLE_OP;
  assign ex_a = gnt ? (gid ? r1_a : r0_a) : '0;
  assign ex_b = gnt ? (gid ? r1_b : r0_b) : '0;
  assign ex_din = gnt ? (gid ? r1_din : r0_din) : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_ans = rsp_valid_q ? ex_ans : '0;
  assign rsp_flag = rsp_valid_q ? ex_flag : 2'b00;
  assign lock_brk = lock_brk_q;
`ifdef EXS_CTX_CHECK_EN
  assign ctx_err = ctx_err_q;
  always_ff @(posedge clk)
    ctx_err_q <= reset ? 1'b0 : gnt & ctx_bad;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      locked_q <= 1'b0;
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= 1'b0;
      lock_brk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      locked_q <= locked_d;
      cnt_q <= cnt_d;
      rsp_valid_q <= gnt;
      rsp_id_q <= gnt & gid;
      lock_brk_q <= brk;
    end
  end
endmodule

// File: tb/tb_exec_share_arbiter.sv
// tb_exec_share_arbiter: table-driven directed vectors plus hand sequences for lock corner cases.
module tb_exec_share_arbiter;
  localparam logic [5:0] IDL = 6'b011100;
  logic clk = 1'b0, reset = 1'b1;
  logic r0_req = 0, r0_lock = 0, r1_req = 0, r1_lock = 0;
  logic [5:0] r0_op = 0, r1_op = 0, ex_op;
  logic [15:0] r0_a = 0, r0_b = 0, r0_din = 0, r1_a = 0, r1_b = 0, r1_din = 0;
  logic [15:0] ex_a, ex_b, ex_din, ex_ans = 0, rsp_ans;
  logic [1:0] ex_flag = 0, rsp_flag;
  logic r0_gnt, r1_gnt, rsp_valid, rsp_id, lock_brk;
`ifdef EXS_CTX_CHECK_EN
  logic ctx_err;
`endif
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  exec_share_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b), .r0_din(r0_din), .r0_gnt(r0_gnt),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b), .r1_din(r1_din), .r1_gnt(r1_gnt),
    .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b), .ex_din(ex_din), .ex_ans(ex_ans), .ex_flag(ex_flag),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_ans(rsp_ans), .rsp_flag(rsp_flag),
`ifdef EXS_CTX_CHECK_EN
    .ctx_err(ctx_err),
`endif
    .lock_brk(lock_brk)
  );

  typedef struct {
    logic rst, q0, l0; logic [5:0] op0; logic [15:0] a0;
    logic q1, l1; logic [5:0] op1; logic [15:0] a1;
    logic [15:0] ans; logic [1:0] fl;
    logic g0, g1; logic [5:0] eop; logic [15:0] ea;
    logic rv, rid; logic [15:0] rans; logic [1:0] rfl; logic brk;
  } vec_t;
  vec_t v[22];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    r0_req = 0; r0_lock = 0; r0_op = 0; r0_a = 0; r0_b = 0; r0_din = 0;
    r1_req = 0; r1_lock = 0; r1_op = 0; r1_a = 0; r1_b = 0; r1_din = 0;
  endtask

  initial begin
    int n0;
    // rst q0 l0 op0 a0 | q1 l1 op1 a1 | ans fl || g0 g1 eop ea | rv rid rans rfl brk
    v[0]  = '{0,1,0,6'd0,16'd3,   0,0,6'd0,16'd0,  16'd0, 2'd0,  1,0,6'd0,16'd3,  0,0,16'd0, 2'd0,0};
    v[1]  = '{0,0,0,6'd0,16'd0,   0,0,6'd0,16'd0,  16'd7, 2'd0,  0,0,IDL, 16'd0,  1,0,16'd7, 2'd0,0};
    v[2]  = '{0,0,0,6'd0,16'd0,   0,0,6'd0,16'd0,  16'd5, 2'd3,  0,0,IDL, 16'd0,  0,0,16'd0, 2'd0,0};
    v[3]  = '{1,1,0,6'd1,16'd9,   1,0,6'd3,16'd9,  16'd0, 2'd0,  0,0,IDL, 16'd0,  0,0,16'd0, 2'd0,0};
    v[4]  = '{0,1,0,6'd2,16'd10,  1,0,6'd3,16'd20, 16'd0, 2'd0,  1,0,6'd2,16'd10, 0,0,16'd0, 2'd0,0};
    v[5]  = '{0,1,0,6'd2,16'd10,  1,0,6'd3,16'd20, 16'd11,2'd1,  0,1,6'd3,16'd20, 1,0,16'd11,2'd1,0};
    v[6]  = '{0,1,0,6'd2,16'd10,  1,0,6'd3,16'd20, 16'd12,2'd2,  1,0,6'd2,16'd10, 1,1,16'd12,2'd2,0};
    v[7]  = '{0,1,0,6'd2,16'd10,  1,0,6'd3,16'd20, 16'd13,2'd3,  0,1,6'd3,16'd20, 1,0,16'd13,2'd3,0};
    v[8]  = '{0,0,0,6'd0,16'd0,   0,0,6'd0,16'd0,  16'd14,2'd1,  0,0,IDL, 16'd0,  1,1,16'd14,2'd1,0};
    v[9]  = '{0,0,0,6'd0,16'd0,   0,0,6'd0,16'd0,  16'd99,2'd3,  0,0,IDL, 16'd0,  0,0,16'd0, 2'd0,0};
    v[10] = '{0,0,0,6'd0,16'd0,   0,0,6'd0,16'd0,  16'd98,2'd3,  0,0,IDL, 16'd0,  0,0,16'd0, 2'd0,0};
    v[11] = '{0,1,0,6'd4,16'd7,   0,0,6'd0,16'd0,  16'd0, 2'd0,  1,0,6'd4,16'd7,  0,0,16'd0, 2'd0,0};
    v[12] = '{1,1,0,6'd1,16'd5,   0,0,6'd0,16'd0,  16'd21,2'd2,  0,0,IDL, 16'd0,  1,0,16'd21,2'd2,0};
    v[13] = '{0,0,0,6'd0,16'd0,   0,0,6'd0,16'd0,  16'd22,2'd1,  0,0,IDL, 16'd0,  0,0,16'd0, 2'd0,0};
    v[14] = '{0,1,1,6'd5,16'd1,   1,0,6'd6,16'd2,  16'd0, 2'd0,  1,0,6'd5,16'd1,  0,0,16'd0, 2'd0,0};
    v[15] = '{0,1,1,6'd5,16'd1,   1,0,6'd6,16'd2,  16'd30,2'd1,  1,0,6'd5,16'd1,  1,0,16'd30,2'd1,0};
    v[16] = '{0,1,1,6'd5,16'd1,   1,0,6'd6,16'd2,  16'd31,2'd1,  1,0,6'd5,16'd1,  1,0,16'd31,2'd1,0};
    v[17] = '{0,1,1,6'd5,16'd1,   1,0,6'd6,16'd2,  16'd32,2'd1,  1,0,6'd5,16'd1,  1,0,16'd32,2'd1,0};
    v[18] = '{0,1,1,6'd5,16'd1,   1,0,6'd6,16'd2,  16'd33,2'd1,  1,0,6'd5,16'd1,  1,0,16'd33,2'd1,0};
    v[19] = '{0,1,1,6'd5,16'd1,   1,0,6'd6,16'd2,  16'd34,2'd1,  0,1,6'd6,16'd2,  1,0,16'd34,2'd1,0};
    v[20] = '{0,1,1,6'd5,16'd1,   1,0,6'd6,16'd2,  16'd35,2'd1,  1,0,6'd5,16'd1,  1,1,16'd35,2'd1,1};
    v[21] = '{0,0,0,6'd0,16'd0,   0,0,6'd0,16'd0,  16'd36,2'd1,  0,0,IDL, 16'd0,  1,0,16'd36,2'd1,0};
    nxt();
    nxt();
    for (int i = 0; i < 22; i++) begin
      reset = v[i].rst;
      r0_req = v[i].q0; r0_lock = v[i].l0; r0_op = v[i].op0; r0_a = v[i].a0; r0_b = v[i].a0 + 16'd1; r0_din = v[i].a0 + 16'd2;
      r1_req = v[i].q1; r1_lock = v[i].l1; r1_op = v[i].op1; r1_a = v[i].a1; r1_b = v[i].a1 + 16'd1; r1_din = v[i].a1 + 16'd2;
      ex_ans = v[i].ans; ex_flag = v[i].fl;
      @(negedge clk);
      chk($sformatf("v%0d r0_gnt", i), r0_gnt, v[i].g0);
      chk($sformatf("v%0d r1_gnt", i), r1_gnt, v[i].g1);
      chk($sformatf("v%0d ex_op", i), ex_op, v[i].eop);
      chk($sformatf("v%0d ex_a", i), ex_a, v[i].ea);
      chk($sformatf("v%0d ex_b", i), ex_b, v[i].g0 ? v[i].a0 + 16'd1 : v[i].g1 ? v[i].a1 + 16'd1 : 16'd0);
      chk($sformatf("v%0d ex_din", i), ex_din, v[i].g0 ? v[i].a0 + 16'd2 : v[i].g1 ? v[i].a1 + 16'd2 : 16'd0);
      chk($sformatf("v%0d rsp_valid", i), rsp_valid, v[i].rv);
      chk($sformatf("v%0d rsp_id", i), rsp_id, v[i].rid);
      chk($sformatf("v%0d rsp_ans", i), rsp_ans, v[i].rans);
      chk($sformatf("v%0d rsp_flag", i), rsp_flag, v[i].rfl);
      chk($sformatf("v%0d lock_brk", i), lock_brk, v[i].brk);
      nxt();
    end
    reset = 0;
    // owner releases its lock by dropping req: the other side gets in with no forced break
    clr();
    r0_req = 1; r0_lock = 1; r0_op = 6'd7; r0_a = 16'd40;
    @(negedge clk);
    chk("drop r0_gnt", r0_gnt, 1);
    nxt();
    clr();
    r1_req = 1; r1_op = 6'd8; r1_a = 16'd50;
    @(negedge clk);
    chk("drop r1_gnt", r1_gnt, 1);
    chk("drop ex_op", ex_op, 6'd8);
    nxt();
    clr();
    @(negedge clk);
    chk("drop lock_brk", lock_brk, 0);
    chk("drop rsp_id", rsp_id, 1);
    nxt();
    // lock_cnt only advances while the other side is waiting
    r0_req = 1; r0_lock = 1; r0_op = 6'd9;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("solo%0d r0_gnt", k), r0_gnt, 1);
      nxt();
    end
    r1_req = 1; r1_op = 6'd10;
    n0 = 0;
    for (int k = 0; k < 20 && !r1_gnt; k++) begin
      @(negedge clk);
      if (r0_gnt) n0++;
      if (!r1_gnt) nxt();
    end
    chk("wait r1_gnt", r1_gnt, 1);
    chk("locked grants", n0, 4);
    nxt();
    @(negedge clk);
    chk("brk pulse", lock_brk, 1);
    nxt();
    clr();
    @(negedge clk);
    chk("brk clear", lock_brk, 0);
`ifdef EXS_CTX_CHECK_EN
    nxt();
    r0_req = 1; r0_op = 6'd0;
    @(negedge clk);
    chk("ctx own r0", r0_gnt, 1);
    nxt();
    clr();
    r1_req = 1; r1_op = 6'b010000;
    @(negedge clk);
    chk("ctx r1_gnt", r1_gnt, 1);
    chk("ctx ex_op", ex_op, IDL);
    nxt();
    clr();
    @(negedge clk);
    chk("ctx rsp_valid", rsp_valid, 1);
    chk("ctx rsp_id", rsp_id, 1);
    chk("ctx_err", ctx_err, 1);
    r1_req = 1; r1_op = 6'b011000;
    @(negedge clk);
    chk("ctx owner op", ex_op, 6'b011000);
    nxt();
    clr();
    @(negedge clk);
    chk("ctx_err clear", ctx_err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
